axi4_lite_cmd_master: RTL and testbench

AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

---
 rtl/axi_lib_pkg.sv | 21 ++
 rtl/axi4_lite_cmd_master_if.sv | 39 +++
 rtl/axi4_lite_cmd_master.sv | 190 +++++++++++++++++++
 tb/tb_axi4_lite_cmd_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lib_pkg.sv
// Shared AXI definitions for the AXI4-lite command master.
//   AXI4_RESP_*          : response codes carried on bresp/rresp/rsp_resp
//   st_axi_lite_master_t : command-master FSM states
package axi_lib_pkg;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5,
    HALT  = 3'd6
  } st_axi_lite_master_t;

endpackage

// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-lite bus bundle.
//   master modport : drives aw/w/ar channels and bready/rready
//   slave  modport : drives the ready/response side
interface ifc_axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// AXI4-lite command master: turns one command at a time into an AXI4-lite
// read or write and returns the slave response.
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_write/addr/wdata/wstrb : command payload
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata/resp/timeout: response payload
//   halted                : set after a response-phase timeout, cleared by reset
//   if_axi                : AXI4-lite master port
module axi4_lite_cmd_master
  import axi_lib_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    halted,
  ifc_axi4_lite.master            if_axi
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  st_axi_lite_master_t state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    to_q, to_d;

  logic awvalid, wvalid, arvalid, bready, rready;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, last_cycle;

  // Each write channel drops its valid once its own handshake is recorded.
  assign awvalid = (state_q == WRITE) && !aw_done_q;
  assign wvalid  = (state_q == WRITE) && !w_done_q;
  assign arvalid = (state_q == RADDR);
  assign bready  = (state_q == WRESP);
  assign rready  = (state_q == RDATA);

  assign aw_hs = awvalid && if_axi.awready;
  assign w_hs  = wvalid  && if_axi.wready;
  assign ar_hs = arvalid && if_axi.arready;
  assign b_hs  = bready  && if_axi.bvalid;
  assign r_hs  = rready  && if_axi.rvalid;

  // Counter sits at k-1 in the k-th ready cycle, so CNT_LAST marks the
  // final cycle of the window.
  assign last_cycle = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    to_d      = to_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WRITE : RADDR;
        end
      end
      WRITE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          cnt_d   = '0;
          state_d = WRESP;
        end
      end
      WRESP: begin
        // A handshake in the final window cycle beats the timeout.
        if (b_hs) begin
          rdata_d = '0;
          resp_d  = if_axi.bresp;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (last_cycle) begin
          rdata_d = '0;
          resp_d  = AXI4_RESP_SLVERR;
          to_d    = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RADDR: begin
        if (ar_hs) begin
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          rdata_d = if_axi.rdata;
          resp_d  = if_axi.rresp;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (last_cycle) begin
          rdata_d = '0;
          resp_d  = AXI4_RESP_SLVERR;
          to_d    = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = to_q ? HALT : IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign halted      = (state_q == HALT);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = to_q;

  assign if_axi.awvalid = awvalid;
  assign if_axi.awaddr  = addr_q;
  assign if_axi.awprot  = 3'b000;
  assign if_axi.wvalid  = wvalid;
  assign if_axi.wdata   = wdata_q;
  assign if_axi.wstrb   = wstrb_q;
  assign if_axi.bready  = bready;
  assign if_axi.arvalid = arvalid;
  assign if_axi.araddr  = addr_q;
  assign if_axi.arprot  = 3'b000;
  assign if_axi.rready  = rready;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: table of commands against a delay-
// configurable AXI4-lite slave model, responses checked through a queue.
module tb_axi4_lite_cmd_master;
  import axi_lib_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout, halted;

  ifc_axi4_lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

  axi4_lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .halted(halted),
    .if_axi(axi)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, ar_dly, lat_dly; // lat_dly<0: never respond
    logic [1:0]  slv_resp;
    logic [31:0] slv_rdata;
    int          rsp_hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
    int          exp_rdy;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  // slave model configuration and state
  int aw_dly, w_dly, ar_dly, lat_dly;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic [1:0]  slv_resp;
  logic [31:0] slv_rdata;

  // monitor state
  logic        cmd_hs, rsp_done, rsp_seen, stable_bad, quiet_bad;
  int          aw_n, w_n, ar_n, rdy_n;
  logic [31:0] aw_addr_s, ar_addr_s, wdata_s, hold_rdata;
  logic [3:0]  wstrb_s;
  logic [2:0]  prot_s;
  logic [1:0]  hold_resp;
  logic        hold_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_update();
    if (axi.awvalid) begin
      if (aw_wait >= aw_dly) axi.awready = 1'b1;
      else begin axi.awready = 1'b0; aw_wait++; end
    end else begin axi.awready = 1'b0; aw_wait = 0; end
    if (axi.wvalid) begin
      if (w_wait >= w_dly) axi.wready = 1'b1;
      else begin axi.wready = 1'b0; w_wait++; end
    end else begin axi.wready = 1'b0; w_wait = 0; end
    if (axi.arvalid) begin
      if (ar_wait >= ar_dly) axi.arready = 1'b1;
      else begin axi.arready = 1'b0; ar_wait++; end
    end else begin axi.arready = 1'b0; ar_wait = 0; end
    if (axi.bready) begin
      if (lat_dly >= 0 && b_wait >= lat_dly) begin axi.bvalid = 1'b1; axi.bresp = slv_resp; end
      else begin axi.bvalid = 1'b0; b_wait++; end
    end else begin axi.bvalid = 1'b0; b_wait = 0; end
    if (axi.rready) begin
      if (lat_dly >= 0 && r_wait >= lat_dly) begin
        axi.rvalid = 1'b1; axi.rresp = slv_resp; axi.rdata = slv_rdata;
      end else begin axi.rvalid = 1'b0; r_wait++; end
    end else begin axi.rvalid = 1'b0; r_wait = 0; end
  endtask

  // Sampled after the falling edge: these values are what the next rising edge sees.
  task automatic monitor();
    exp_t e;
    if (cmd_valid && cmd_ready) cmd_hs = 1'b1;
    if (axi.awvalid && axi.awready) begin aw_n++; aw_addr_s = axi.awaddr; prot_s |= axi.awprot; end
    if (axi.wvalid && axi.wready) begin w_n++; wdata_s = axi.wdata; wstrb_s = axi.wstrb; end
    if (axi.arvalid && axi.arready) begin ar_n++; ar_addr_s = axi.araddr; prot_s |= axi.arprot; end
    if (axi.bready || axi.rready) rdy_n++;
    if (rsp_valid) begin
      if (!rsp_seen) begin
        rsp_seen = 1'b1; hold_rdata = rsp_rdata; hold_resp = rsp_resp; hold_to = rsp_timeout;
      end else if (rsp_rdata !== hold_rdata || rsp_resp !== hold_resp || rsp_timeout !== hold_to) begin
        stable_bad = 1'b1;
      end
      if (cmd_ready || axi.awvalid || axi.wvalid || axi.arvalid || axi.bready || axi.rready)
        quiet_bad = 1'b1;
      if (rsp_ready) begin
        chk("sb_depth", 64'(exp_q.size()), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
        rsp_done = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    slave_update();
    #2;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int rsp_wait;
    exp_t e;
    aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly; lat_dly = v.lat_dly;
    slv_resp = v.slv_resp; slv_rdata = v.slv_rdata;
    aw_n = 0; w_n = 0; ar_n = 0; rdy_n = 0; prot_s = '0;
    aw_addr_s = '0; ar_addr_s = '0; wdata_s = '0; wstrb_s = '0;
    cmd_hs = 1'b0; rsp_done = 1'b0; rsp_seen = 1'b0; stable_bad = 1'b0; quiet_bad = 1'b0;
    e.rdata = v.exp_rdata; e.resp = v.exp_resp; e.to = v.exp_to;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb; rsp_ready = 1'b0;
    rsp_wait = 0;
    for (int i = 0; i < 300 && !rsp_done; i++) begin
      cycle();
      if (cmd_hs) cmd_valid = 1'b0;
      if (rsp_valid && !rsp_done) begin
        rsp_wait++;
        rsp_ready = (rsp_wait > v.rsp_hold);
      end else begin
        rsp_ready = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("rsp_done_in_budget", 64'(rsp_done), 64'(1));
    chk("rsp_stable", 64'(stable_bad), 64'(0));
    chk("resp_quiet", 64'(quiet_bad), 64'(0));
    chk("aw_count", 64'(aw_n), v.write ? 64'(1) : 64'(0));
    chk("w_count", 64'(w_n), v.write ? 64'(1) : 64'(0));
    chk("ar_count", 64'(ar_n), v.write ? 64'(0) : 64'(1));
    chk("addr_seen", v.write ? 64'(aw_addr_s) : 64'(ar_addr_s), 64'(v.addr));
    chk("wdata_seen", 64'(wdata_s), v.write ? 64'(v.wdata) : 64'(0));
    chk("wstrb_seen", 64'(wstrb_s), v.write ? 64'(v.wstrb) : 64'(0));
    chk("prot_zero", 64'(prot_s), 64'(0));
    chk("ready_cycles", 64'(rdy_n), 64'(v.exp_rdy));
  endtask

  logic halt_bad;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = '0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; lat_dly = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    slv_resp = '0; slv_rdata = '0;
    cmd_hs = 1'b0; rsp_done = 1'b0; rsp_seen = 1'b0; stable_bad = 1'b0; quiet_bad = 1'b0;
    aw_n = 0; w_n = 0; ar_n = 0; rdy_n = 0; prot_s = '0;

    //          wr  addr   wdata         strb aw w  ar lat resp              slv_rdata     hold exp_rdata     exp_resp          to rdy
    vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 0, 0, 0, AXI4_RESP_OKAY,   32'h0,        0,   32'h0,        AXI4_RESP_OKAY,   0, 1};
    vecs[1] = '{0, 32'h14, 32'h0,        4'h0, 0, 0, 0, 2, AXI4_RESP_SLVERR, 32'h12345678, 0,   32'h12345678, AXI4_RESP_SLVERR, 0, 3};
    vecs[2] = '{1, 32'h20, 32'h01020304, 4'h3, 0, 4, 0, 1, AXI4_RESP_OKAY,   32'h0,        5,   32'h0,        AXI4_RESP_OKAY,   0, 2};
    vecs[3] = '{1, 32'h24, 32'hA5A55A5A, 4'h9, 2, 2, 0, 0, AXI4_RESP_EXOKAY, 32'hFFFF0000, 0,   32'h0,        AXI4_RESP_EXOKAY, 0, 1};
    vecs[4] = '{0, 32'h28, 32'h0,        4'h0, 0, 0, 1, 7, AXI4_RESP_OKAY,   32'hCAFEF00D, 2,   32'hCAFEF00D, AXI4_RESP_OKAY,   0, 8};
    vecs[5] = '{0, 32'h2C, 32'h0,        4'h0, 0, 0, 3, 0, AXI4_RESP_DECERR, 32'h0BADF00D, 0,   32'h0BADF00D, AXI4_RESP_DECERR, 0, 1};

    // reset state
    cycle();
    cycle();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_resp", 64'(rsp_resp), 64'(0));
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_axi_vr", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'(0));
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // write response never arrives: bready for exactly TO cycles, then halt
    run_vec('{1, 32'h40, 32'h11223344, 4'hF, 0, 0, 0, -1, AXI4_RESP_OKAY, 32'h0, 0,
              32'h0, AXI4_RESP_SLVERR, 1, TO});
    halt_bad = 1'b0;
    cmd_hs = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!halted || cmd_ready || axi.awvalid || axi.wvalid || axi.arvalid || axi.bready || axi.rready)
        halt_bad = 1'b1;
    end
    cmd_valid = 1'b0;
    chk("halted_set", 64'(halted), 64'(1));
    chk("halted_quiet", 64'(halt_bad), 64'(0));
    chk("halted_no_cmd", 64'(cmd_hs), 64'(0));
    rst_n = 1'b0;
    cycle();
    chk("halt_rst_halted", 64'(halted), 64'(0));
    chk("halt_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    rst_n = 1'b1;
    exp_q.delete();

    // reset while arvalid is up, then back-to-back write and read
    ar_dly = 1000; cmd_hs = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    for (int i = 0; i < 20 && !cmd_hs; i++) cycle();
    cmd_valid = 1'b0;
    cycle(); cycle(); cycle();
    chk("arvalid_before_rst", 64'(axi.arvalid), 64'(1));
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_arvalid", 64'(axi.arvalid), 64'(0));
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    run_vec('{1, 32'h34, 32'h5EED1234, 4'hC, 1, 1, 0, 1, AXI4_RESP_OKAY, 32'h0, 0,
              32'h0, AXI4_RESP_OKAY, 0, 2});
    run_vec('{0, 32'h34, 32'h0, 4'h0, 0, 0, 0, 0, AXI4_RESP_OKAY, 32'h5EED1234, 0,
              32'h5EED1234, AXI4_RESP_OKAY, 0, 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
